// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle RV32 subset core (lw, sw, R-type, I-type ALU, beq, jal).
// Datapath strobes and selects decode combinationally from the registered state and instruction fields.
module multicycle_control_fsm #(
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_req,
  output logic       adr_src,
  output logic       illegal,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] TRAP     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // State register; reset lands in FETCH without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else           state_d = FETCH;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP_HALT ? TRAP : FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_SW) state_d = MEMWRITE;
        else             state_d = MEMREAD;
      end
      MEMREAD: begin
        if (mem_ready) state_d = MEMWB;
        else           state_d = MEMREAD;
      end
      MEMWRITE: begin
        if (mem_ready) state_d = FETCH;
        else           state_d = MEMWRITE;
      end
      MEMWB, ALUWB, BEQ:  state_d = FETCH;
      EXECR, EXECI, JAL:  state_d = ALUWB;
      TRAP:               state_d = TRAP;
      default:            state_d = FETCH;
    endcase
  end

  // Output decode: defaults first, then each state overrides only its own fields.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    mem_req     = 1'b0;
    adr_src     = 1'b0;
    illegal     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 3'b000;

    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
      end
      EXECR, EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = (state_q == EXECI) ? 2'b01 : 2'b00;
        case (funct3)
          3'b000:  alu_control = ((state_q == EXECR) && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = 3'b001;
        pc_write    = zero;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    case (op)
      OP_LW, OP_I: imm_src = 2'b00;
      OP_SW:       imm_src = 2'b01;
      OP_BEQ:      imm_src = 2'b10;
      OP_JAL:      imm_src = 2'b11;
      default:     imm_src = 2'b00;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each instruction is expanded into its phase list and
// every cycle's state and output vector is compared with a table-driven reference.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_write, mem_req, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  logic       n_pc_write, n_ir_write, n_reg_write, n_mem_write, n_mem_req, n_adr_src, n_illegal;
  logic [1:0] n_alu_src_a, n_alu_src_b, n_result_src, n_imm_src;
  logic [2:0] n_alu_control;
  logic [3:0] n_state;

  int checks   = 0;
  int failures = 0;
  int mw_count = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .mem_req(mem_req), .adr_src(adr_src), .illegal(illegal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
    .alu_control(alu_control), .state(state)
  );

  multicycle_control_fsm #(.TRAP_HALT(1'b0)) dut_nohalt (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .pc_write(n_pc_write), .ir_write(n_ir_write), .reg_write(n_reg_write),
    .mem_write(n_mem_write), .mem_req(n_mem_req), .adr_src(n_adr_src), .illegal(n_illegal),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .result_src(n_result_src),
    .imm_src(n_imm_src), .alu_control(n_alu_control), .state(n_state)
  );

  wire [17:0] obs = {pc_write, ir_write, reg_write, mem_write, mem_req, adr_src, illegal,
                     alu_src_a, alu_src_b, result_src, imm_src, alu_control};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected output vector for a phase, read straight off the per-state output table.
  function automatic logic [17:0] exp_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic mr);
    logic pcw = 0, irw = 0, rw = 0, mw = 0, mreq = 0, adr = 0, ill = 0;
    logic [1:0] a = 0, b = 0, res = 0, imm = 0;
    logic [2:0] alu = 0;
    case (o)
      7'b0000011, 7'b0010011: imm = 2'd0;
      7'b0100011:             imm = 2'd1;
      7'b1100011:             imm = 2'd2;
      7'b1101111:             imm = 2'd3;
      default:                imm = 2'd0;
    endcase
    case (st)
      0:  begin mreq = 1; a = 0; b = 2; res = 2; irw = mr; pcw = mr; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin res = 1; rw = 1; end
      5:  begin mreq = 1; adr = 1; mw = 1; end
      6, 7: begin
        a = 2; b = (st == 7) ? 2'd1 : 2'd0;
        if (f3 == 3'b000)      alu = (st == 6 && f7) ? 3'd1 : 3'd0;
        else if (f3 == 3'b010) alu = 3'd5;
        else if (f3 == 3'b110) alu = 3'd3;
        else if (f3 == 3'b111) alu = 3'd2;
        else                   alu = 3'd0;
      end
      8:  begin res = 0; rw = 1; end
      9:  begin a = 2; b = 0; alu = 1; pcw = z; end
      10: begin a = 1; b = 2; pcw = 1; end
      11: ill = 1;
      default: ill = 0;
    endcase
    return {pcw, irw, rw, mw, mreq, adr, ill, a, b, res, imm, alu};
  endfunction

  // One clock: drive inputs, check at the falling edge, return just after the next rising edge.
  task automatic step(input int exp_st, input int exp_st_nohalt, input logic mr);
    mem_ready = mr;
    zero = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_val($sformatf("state(exp %0d)", exp_st), 32'(state), 32'(exp_st));
    check_val($sformatf("outputs(st %0d)", exp_st), 32'(obs),
              32'(exp_out(exp_st, op, funct3, funct7b5, zero, mem_ready)));
    check_val("state_nohalt", 32'(n_state), 32'(exp_st_nohalt));
    if (mem_write) mw_count++;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH; a stall argument of -1 picks a random wait count.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fetch_stall, input int mem_stall);
    int phases[$];
    int stalls;
    op = o; funct3 = f3; funct7b5 = f7;
    case (o)
      7'b0000011: phases = '{0, 1, 2, 3, 4};
      7'b0100011: phases = '{0, 1, 2, 5};
      7'b0110011: phases = '{0, 1, 6, 8};
      7'b0010011: phases = '{0, 1, 7, 8};
      7'b1100011: phases = '{0, 1, 9};
      default:    phases = '{0, 1, 10, 8};
    endcase
    foreach (phases[i]) begin
      if (phases[i] == 0 || phases[i] == 3 || phases[i] == 5) begin
        stalls = (phases[i] == 0) ? fetch_stall : mem_stall;
        if (stalls < 0) stalls = $urandom_range(0, 3);
        for (int s = 0; s <= stalls; s++) step(phases[i], phases[i], (s == stalls));
      end else begin
        step(phases[i], phases[i], 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_val({tag, "_state"}, 32'(state), 32'd0);
    check_val({tag, "_nohalt_state"}, 32'(n_state), 32'd0);
    check_val({tag, "_outputs"}, 32'(obs), 32'(exp_out(0, op, funct3, funct7b5, zero, mem_ready)));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [6:0] legal_op(input int k);
    case (k)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  initial begin
    rst = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_val("reset_state", 32'(state), 32'd0);
    check_val("reset_outputs", 32'(obs), 32'(exp_out(0, op, funct3, funct7b5, zero, mem_ready)));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int n = 0; n < 40; n++)
      run_instr(legal_op($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), -1, -1);

    run_instr(7'b0000011, 3'b010, 1'b0, 0, 0);
    mw_count = 0;
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 3);
    check_val("sw_mem_write_cycles", 32'(mw_count), 32'd4);
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 0);
    run_instr(7'b0010011, 3'b000, 1'b1, 2, 0);
    for (int n = 0; n < 6; n++) run_instr(7'b1100011, 3'b000, 1'b0, 0, 0);

    // Reset arriving while MEMREAD is stalled.
    op = 7'b0000011;
    step(0, 0, 1'b1);
    step(1, 1, 1'b1);
    step(2, 2, 1'b1);
    step(3, 3, 1'b0);
    mem_ready = 1'b0;
    async_reset_check("midstall_rst");

    // Illegal opcode: halting instance parks in TRAP, the other returns to FETCH.
    op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0;
    step(0, 0, 1'b1);
    step(1, 1, 1'b0);
    for (int n = 0; n < 10; n++) step(11, 0, 1'b0);
    async_reset_check("trap_rst");

    for (int n = 0; n < 8; n++)
      run_instr(legal_op($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
